operand_bank_loader: RTL



---
 rtl/operand_bank_loader_pkg.sv | 15 +
 rtl/operand_bank_loader_if.sv | 25 ++
 rtl/operand_bank_loader.sv | 89 ++++++++
 3 files changed

// File: rtl/operand_bank_loader_pkg.sv
// Shared constants and state encoding for the 25-operand bank loader.
package operand_bank_loader_pkg;
   localparam int N_WORDS   = 25;
   localparam int WORD_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int ADDR_STEP = 4;
   localparam int IDX_W     = $clog2(N_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/operand_bank_loader_if.sv
// Memory read port plus flat operand bus; master is the loader, slave is memory/consumer side.
interface operand_bank_loader_if;
   import operand_bank_loader_pkg::*;

   logic                        start;
   logic [ADDR_W-1:0]           base_addr;
   logic                        mem_rd;
   logic [ADDR_W-1:0]           mem_addr;
   logic [WORD_W-1:0]           mem_rdata;
   logic                        mem_rvalid;
   logic                        busy;
   logic                        done;
   logic                        bank_valid;
   logic [N_WORDS*WORD_W-1:0]   d_flat;

   modport master (
      input  start, base_addr, mem_rdata, mem_rvalid,
      output mem_rd, mem_addr, busy, done, bank_valid, d_flat
   );

   modport slave (
      output start, base_addr, mem_rdata, mem_rvalid,
      input  mem_rd, mem_addr, busy, done, bank_valid, d_flat
   );
endinterface

// File: rtl/operand_bank_loader.sv
// Fetches N_WORDS words one read at a time into a register bank; done at cycle 2*N_WORDS+1 with 1-cycle memory.
// Memory latency stalls in WAIT indefinitely; start while busy is dropped.
module operand_bank_loader
   import operand_bank_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   operand_bank_loader_if.master bus
);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

   state_t              state;
   logic [IDX_W-1:0]    index;
   logic [ADDR_W-1:0]   addr_reg;
   logic [ADDR_W-1:0]   addr_next;
   logic                capture;
   logic [WORD_W-1:0]   bank [N_WORDS];

   assign capture   = (state == ST_WAIT) && bus.mem_rvalid;
   assign addr_next = addr_reg + STEP;

   // Outputs are registered, so they are loaded on the transition into each state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         index          <= '0;
         addr_reg       <= '0;
         bus.mem_rd     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.bank_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state          <= ST_REQ;
                  index          <= '0;
                  addr_reg       <= bus.base_addr;
                  bus.bank_valid <= 1'b0;
                  bus.busy       <= 1'b1;
                  bus.mem_rd     <= 1'b1;
                  bus.mem_addr   <= bus.base_addr;
               end
            end
            ST_REQ: begin
               bus.mem_rd <= 1'b0;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.mem_rvalid) begin
                  addr_reg <= addr_next;
                  if (index == LAST_IDX) begin
                     state          <= ST_DONE;
                     bus.done       <= 1'b1;
                     bus.bank_valid <= 1'b1;
                  end else begin
                     index        <= index + 1'b1;
                     state        <= ST_REQ;
                     bus.mem_rd   <= 1'b1;
                     bus.mem_addr <= addr_next;
                  end
               end
            end
            ST_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_WORDS; i++) begin : g_slot
      logic slot_we;
      assign slot_we = capture && (index == IDX_W'(i));

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            bank[i] <= '0;
         else if (slot_we)
            bank[i] <= bus.mem_rdata;
      end

      assign bus.d_flat[i*WORD_W +: WORD_W] = bank[i];
   end
endmodule
